// File: rtl/mbox_mutex_arb.sv
`default_nettype none
// ============================================================================
//  Module   : mbox_mutex_arb
//  Purpose  : Hardware mutex for the message-box subsystem. Grants exclusive
//             ownership of one shared mailbox to one of N_REQ requesters,
//             using round-robin arbitration and lock-until-release semantics.
//             An optional hold timeout revokes a stuck owner, reports it and
//             locks that requester out until it drops its request.
//  Revision : 1.0  initial release
// ============================================================================
module mbox_mutex_arb #(
    parameter  int N_REQ    = 4,
    parameter  int HOLD_MAX = 0,
    localparam int IDW      = $clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] i_req,
    output logic [N_REQ-1:0] o_grant,
    output logic             o_busy,
    output logic [IDW-1:0]   o_owner_id,
    output logic             o_timeout_pulse,
    output logic [IDW-1:0]   o_timeout_id
);

    // Hold counter is at least one bit wide so HOLD_MAX=0 still elaborates;
    // in that case it simply never leaves zero.
    localparam int               HCW          = (HOLD_MAX > 0) ? $clog2(HOLD_MAX + 1) : 1;
    localparam logic [HCW-1:0]   c_HOLD_MAX   = HCW'(HOLD_MAX);
    localparam logic [HCW-1:0]   c_HOLD_START = HCW'((HOLD_MAX > 0) ? 1 : 0);
    localparam logic [N_REQ-1:0] c_ONE        = N_REQ'(1);
    localparam logic [IDW-1:0]   c_LAST       = IDW'(N_REQ - 1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_OWNED = 1'b1
    } state_t;

    state_t             r_state;
    logic [N_REQ-1:0]   r_grant;
    logic               r_busy;
    logic [IDW-1:0]     r_owner;
    logic               r_timeout_pulse;
    logic [IDW-1:0]     r_timeout_id;
    logic [IDW-1:0]     r_rr_ptr;
    logic [N_REQ-1:0]   r_lockout;
    logic [HCW-1:0]     r_hold_cnt;

    logic [N_REQ-1:0]   w_elig;
    logic               w_found_hi;
    logic [IDW-1:0]     w_pick_hi;
    logic               w_found_lo;
    logic [IDW-1:0]     w_pick_lo;
    logic               w_found;
    logic [IDW-1:0]     w_pick;
    logic               w_owner_req;
    logic               w_hold_expired;
    logic               w_hold_inc;

    // A revoked requester stays ineligible until it has dropped its request.
    assign w_elig = i_req & ~r_lockout;

    // Round-robin pick: the lowest eligible index at or above rr_ptr wins;
    // if none exists the search wraps and the lowest eligible index wins.
    always_comb begin
        w_found_hi = 1'b0;
        w_pick_hi  = '0;
        w_found_lo = 1'b0;
        w_pick_lo  = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (w_elig[i]) begin
                w_found_lo = 1'b1;
                w_pick_lo  = IDW'(i);
                if (i >= int'(r_rr_ptr)) begin
                    w_found_hi = 1'b1;
                    w_pick_hi  = IDW'(i);
                end
            end
        end
    end

    assign w_found = w_found_lo;
    assign w_pick  = w_found_hi ? w_pick_hi : w_pick_lo;

    // The owner's own request line decides release; others are ignored.
    assign w_owner_req = i_req[r_owner];

    // Expiry when the grant has already been high for HOLD_MAX cycles; the
    // counter stops at HOLD_MAX so it can never wrap.
    assign w_hold_expired = (HOLD_MAX > 0) && (r_hold_cnt == c_HOLD_MAX);
    assign w_hold_inc     = (HOLD_MAX > 0) && (r_hold_cnt != c_HOLD_MAX);

    // Pointer to the requester after the given one, wrapping at N_REQ.
    function automatic logic [IDW-1:0] f_next_id(input logic [IDW-1:0] id);
        return (id == c_LAST) ? '0 : id + 1'b1;
    endfunction

    // Mutex state machine with all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= S_IDLE;
            r_grant         <= '0;
            r_busy          <= 1'b0;
            r_owner         <= '0;
            r_timeout_pulse <= 1'b0;
            r_timeout_id    <= '0;
            r_rr_ptr        <= '0;
            r_lockout       <= '0;
            r_hold_cnt      <= '0;
        end else begin
            // Strobe defaults low; lockout bits fall away wherever req is low.
            r_timeout_pulse <= 1'b0;
            r_lockout       <= r_lockout & i_req;

            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_state    <= S_OWNED;
                        r_grant    <= c_ONE << w_pick;
                        r_busy     <= 1'b1;
                        r_owner    <= w_pick;
                        r_hold_cnt <= c_HOLD_START;
                    end
                end

                S_OWNED: begin
                    if (!w_owner_req) begin
                        // Voluntary release; takes priority over a timeout
                        // landing on the same edge.
                        r_state    <= S_IDLE;
                        r_grant    <= '0;
                        r_busy     <= 1'b0;
                        r_owner    <= '0;
                        r_rr_ptr   <= f_next_id(r_owner);
                        r_hold_cnt <= '0;
                    end else if (w_hold_expired) begin
                        // Revoke the owner, report it and lock it out. The
                        // grant vector is exactly the owner's one-hot mask.
                        r_state         <= S_IDLE;
                        r_grant         <= '0;
                        r_busy          <= 1'b0;
                        r_owner         <= '0;
                        r_timeout_pulse <= 1'b1;
                        r_timeout_id    <= r_owner;
                        r_lockout       <= (r_lockout & i_req) | r_grant;
                        r_rr_ptr        <= f_next_id(r_owner);
                        r_hold_cnt      <= '0;
                    end else if (w_hold_inc) begin
                        r_hold_cnt <= r_hold_cnt + 1'b1;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_grant <= '0;
                    r_busy  <= 1'b0;
                    r_owner <= '0;
                end
            endcase
        end
    end

    assign o_grant         = r_grant;
    assign o_busy          = r_busy;
    assign o_owner_id      = r_owner;
    assign o_timeout_pulse = r_timeout_pulse;
    assign o_timeout_id    = r_timeout_id;

endmodule
`default_nettype wire

// File: tb/tb_mbox_mutex_arb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mbox_mutex_arb
//  Purpose  : Directed self-checking bench for mbox_mutex_arb. Instance u_dut
//             runs with HOLD_MAX=8, instance u_dut_nt with timeout disabled.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mbox_mutex_arb;

    localparam int N_REQ = 4;
    localparam int IDW   = 2;

    logic             clk;
    logic             rst_n;
    logic [N_REQ-1:0] r_req_a;
    logic [N_REQ-1:0] w_grant_a;
    logic             w_busy_a;
    logic [IDW-1:0]   w_owner_a;
    logic             w_tp_a;
    logic [IDW-1:0]   w_tid_a;
    logic [N_REQ-1:0] r_req_b;
    logic [N_REQ-1:0] w_grant_b;
    logic             w_busy_b;
    logic [IDW-1:0]   w_owner_b;
    logic             w_tp_b;
    logic [IDW-1:0]   w_tid_b;

    int n_checks;
    int n_errors;

    mbox_mutex_arb #(.N_REQ(N_REQ), .HOLD_MAX(8)) u_dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_req           (r_req_a),
        .o_grant         (w_grant_a),
        .o_busy          (w_busy_a),
        .o_owner_id      (w_owner_a),
        .o_timeout_pulse (w_tp_a),
        .o_timeout_id    (w_tid_a)
    );

    mbox_mutex_arb #(.N_REQ(N_REQ), .HOLD_MAX(0)) u_dut_nt (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_req           (r_req_b),
        .o_grant         (w_grant_b),
        .o_busy          (w_busy_b),
        .o_owner_id      (w_owner_b),
        .o_timeout_pulse (w_tp_b),
        .o_timeout_id    (w_tid_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges and settle 1 ns past the last one.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    logic [N_REQ-1:0] rr_order [4];
    logic [N_REQ-1:0] cur;
    int               bad_cycles;

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        r_req_a  = '0;
        r_req_b  = '0;
        rr_order[0] = 4'b0010;
        rr_order[1] = 4'b0100;
        rr_order[2] = 4'b1000;
        rr_order[3] = 4'b0001;

        // Reset state
        #12;
        check("rst_grant", w_grant_a, 4'b0000);
        check("rst_busy",  w_busy_a,  1'b0);
        check("rst_owner", w_owner_a, 2'd0);
        check("rst_tp",    w_tp_a,    1'b0);
        check("rst_tid",   w_tid_a,   2'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset in the middle of an ownership period
        r_req_a = 4'b0100;
        step(1);
        check("pre_rst_grant", w_grant_a, 4'b0100);
        check("pre_rst_owner", w_owner_a, 2'd2);
        check("pre_rst_busy",  w_busy_a,  1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_grant", w_grant_a, 4'b0000);
        check("mid_rst_busy",  w_busy_a,  1'b0);
        check("mid_rst_owner", w_owner_a, 2'd0);
        #2;
        rst_n   = 1'b1;
        r_req_a = 4'b0000;
        step(1);
        r_req_a = 4'b1111;
        step(1);
        check("post_rst_grant", w_grant_a, 4'b0001);
        check("post_rst_owner", w_owner_a, 2'd0);

        // Round-robin fairness: 2 grant cycles, 1-cycle drop, re-request
        cur = 4'b0001;
        for (int i = 0; i < 4; i++) begin
            step(1);
            check("rr_hold", w_grant_a, cur);
            r_req_a = 4'b1111 & ~cur;
            step(1);
            check("rr_gap", w_grant_a, 4'b0000);
            check("rr_gap_busy", w_busy_a, 1'b0);
            r_req_a = 4'b1111;
            step(1);
            check("rr_next", w_grant_a, rr_order[i]);
            cur = rr_order[i];
        end
        r_req_a = 4'b0000;
        step(1);
        check("rr_release", w_grant_a, 4'b0000);
        step(1);

        // No preemption while the owner holds its request (rr_ptr=1 here)
        r_req_a = 4'b0100;
        step(1);
        check("np_grant", w_grant_a, 4'b0100);
        r_req_a = 4'b1101;
        for (int i = 0; i < 5; i++) begin
            step(1);
            check("np_hold", w_grant_a, 4'b0100);
        end
        r_req_a = 4'b1001;
        step(1);
        check("np_release", w_grant_a, 4'b0000);
        step(1);
        check("np_next", w_grant_a, 4'b1000);
        check("np_next_owner", w_owner_a, 2'd3);
        r_req_a = 4'b0000;
        step(2);

        // Timeout: requester 1 never lets go
        r_req_a = 4'b0010;
        step(1);
        for (int i = 0; i < 8; i++) begin
            check("to_grant", w_grant_a, 4'b0010);
            check("to_no_pulse", w_tp_a, 1'b0);
            step(1);
        end
        check("to_revoked", w_grant_a, 4'b0000);
        check("to_pulse", w_tp_a, 1'b1);
        check("to_id", w_tid_a, 2'd1);
        check("to_busy", w_busy_a, 1'b0);
        step(1);
        check("to_pulse_once", w_tp_a, 1'b0);
        check("to_id_held", w_tid_a, 2'd1);
        check("to_locked", w_grant_a, 4'b0000);
        step(3);
        check("to_still_locked", w_grant_a, 4'b0000);
        r_req_a = 4'b0000;
        step(1);
        check("to_drop", w_grant_a, 4'b0000);
        r_req_a = 4'b0010;
        step(1);
        check("to_regrant", w_grant_a, 4'b0010);
        check("to_regrant_owner", w_owner_a, 2'd1);
        r_req_a = 4'b0000;
        step(2);

        // Release and timeout on the same edge: release wins
        r_req_a = 4'b1000;
        step(1);
        for (int i = 0; i < 7; i++) begin
            check("tie_grant", w_grant_a, 4'b1000);
            step(1);
        end
        check("tie_grant8", w_grant_a, 4'b1000);
        r_req_a = 4'b0000;
        step(1);
        check("tie_drop", w_grant_a, 4'b0000);
        check("tie_no_pulse", w_tp_a, 1'b0);
        check("tie_tid_kept", w_tid_a, 2'd1);
        r_req_a = 4'b1000;
        step(1);
        check("tie_regrant", w_grant_a, 4'b1000);
        check("tie_no_pulse2", w_tp_a, 1'b0);
        r_req_a = 4'b0000;
        step(2);

        // Timeout disabled: a long hold is never revoked
        r_req_b = 4'b0001;
        step(1);
        bad_cycles = 0;
        for (int i = 0; i < 1000; i++) begin
            if (w_grant_b !== 4'b0001 || w_tp_b !== 1'b0)
                bad_cycles++;
            step(1);
        end
        check("nt_bad_cycles", bad_cycles, 0);
        check("nt_grant_end", w_grant_b, 4'b0001);
        check("nt_busy_end", w_busy_b, 1'b1);
        check("nt_owner_end", w_owner_b, 2'd0);
        check("nt_tid", w_tid_b, 2'd0);
        r_req_b = 4'b0000;
        step(1);
        check("nt_release", w_grant_b, 4'b0000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mbox_mutex_arb.md
# mbox_mutex_arb

Parametrised hardware mutex for the message-box subsystem: arbitrates exclusive ownership of one shared mailbox resource among N_REQ requesters. It replaces the two-requester fixed mutex with round-robin fair arbitration among simultaneous requesters and lock-until-release semantics, so a granted owner keeps the lock while others wait. It also adds an optional hold timeout that revokes a stuck owner and reports the event.

## Interface
- N_REQ, 4: number of requesters; legal range 2..32.
- HOLD_MAX, 0: maximum grant length in cycles; 0 disables the timeout; legal range 0..65535.
- IDW, derived: $clog2(N_REQ).

- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; one clock, asynchronous assert, active-low.
- req  in  N_REQ  level request per requester; held high for the whole ownership period.
- grant  out  N_REQ  registered grant; one-hot or zero.
- busy  out  1  high while any grant bit is set.
- owner_id  out  IDW  index of the current owner; 0 when not busy.
- timeout_pulse  out  1  one-cycle strobe when an owner is revoked by timeout.
- timeout_id  out  IDW  index of the revoked owner; valid with timeout_pulse and held until the next timeout.

## Operation
- States: IDLE, OWNED.
- IDLE: grant=0. If any eligible req bit is set, pick the first set bit searching upward from rr_ptr with wrap (rr_ptr, rr_ptr+1, ..., N_REQ-1, 0, ...). Register the grant, set owner_id, and go to OWNED.
- Eligible means req[i]=1 and lockout[i]=0.
- OWNED: grant[owner] is held while req[owner]=1. Other requests are ignored; no preemption.
- Release: req[owner]=0 clears grant, sets rr_ptr=(owner+1) mod N_REQ, and returns to IDLE.
- Timeout (HOLD_MAX>0): hold_cnt counts cycles with grant high. When grant has been high for HOLD_MAX cycles, the block:
  - clears grant and returns to IDLE;
  - pulses timeout_pulse and sets timeout_id=owner;
  - sets lockout[owner]=1 and rr_ptr=(owner+1) mod N_REQ.
- Lockout: lockout[i] clears on any cycle where req[i]=0. A revoked requester must drop req before it can win again.
- If release and timeout fall on the same edge, release wins: no timeout_pulse and no lockout.
- Requests from non-owners that appear and drop during OWNED leave no trace; there is no request memory.
- Mutual exclusion invariant: at most one grant bit is high; grant is never high in IDLE.
- hold_cnt width is $clog2(HOLD_MAX+1). It saturates, never wraps, and clears on every entry to IDLE.

## Timing
- Reset (async, mid-operation included) sets these immediately:
  - grant=0, busy=0, owner_id=0;
  - timeout_pulse=0, timeout_id=0;
  - rr_ptr=0, lockout=0, hold_cnt=0, state IDLE.
- Grant latency: req high before edge E in IDLE gives grant high after E (1 cycle).
- Release latency: req[owner] low before edge F gives grant low after F.
- After a release, arbitration resumes at edge F+1, so the earliest next grant appears after F+1. There is always at least one all-zero grant cycle between owners.
- Timeout: grant first high after edge G is held for exactly HOLD_MAX cycles and drops after edge G+HOLD_MAX. timeout_pulse is high during the cycle after G+HOLD_MAX only.
- busy and owner_id change on the same edge as grant.
- All outputs are registered; there are no combinational paths from req.

## Test plan
Parameters: N_REQ=4, HOLD_MAX=8 unless stated.
- Reset mid-ownership: assert rst_n=0 while grant=4'b0100. Required: grant=0, busy=0, owner_id=0 immediately; after release, req=4'b1111 gives grant=4'b0001 (rr_ptr=0).
- Round-robin fairness: hold req=4'b1111, each owner drops req for 1 cycle after 2 cycles of grant, then re-asserts. Required: grant order 0001, 0010, 0100, 1000, 0001, with one zero-grant cycle between owners.
- Hold/no preemption: grant req[2]; raise req[0], req[3] for 5 cycles while req[2] stays high (<8 cycles total). Required: grant stays 4'b0100; after req[2] drops and one idle cycle, grant=4'b1000.
- Timeout: req[1] held high indefinitely, others 0. Required: grant=4'b0010 for exactly 8 cycles, then timeout_pulse=1 for 1 cycle with timeout_id=1 and grant=0. Grant stays 0 until req[1] drops and re-rises.
- Timeout vs release tie: req[3] drops on the same edge the 8th grant cycle ends. Required: grant drops, timeout_pulse stays 0, no lockout, and an immediate re-request is granted.
- HOLD_MAX=0: req[0] held for 1000 cycles. Required: grant=4'b0001 throughout and timeout_pulse never asserts.
